// File: rtl/bcd_pkg.sv
// Shared definitions for the decimal arithmetic datapath: digit limits,
// FSM state encoding and a digit validity helper.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] BCD_RADIX = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_NEG  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit subtract with borrow: d = x - y - bin, corrected by +10 on
// underflow. Purely combinational; shared by the subtract and negate passes.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic signed [4:0] t;
    logic        [3:0] t_corr;

    // Signed difference; the low nibble plus ten (mod 16) is the corrected digit.
    always_comb begin
        t      = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bin});
        t_corr = t[3:0] + BCD_RADIX;
        bout   = t[4];
        d      = bout ? t_corr : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor producing |a - b| in sign-magnitude form.
// Operands are shifted right one digit per clock (LSD first) and each result
// digit enters the top of the result register, so after DIGITS steps the
// result sits in natural order. A negative raw result is re-walked once more
// as 0 - r to obtain the magnitude.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                neg,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    r_q, r_d;
    logic [W-1:0]    diff_q, diff_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic            neg_q, neg_d;
    logic            inv_q, inv_d;

    logic            ops_valid;
    logic [3:0]      sub_x, sub_y, sub_d;
    logic            sub_bout;
    logic [W-1:0]    r_shift;

    // Every digit of both incoming operands must be a legal BCD digit.
    always_comb begin
        ops_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(a[4*i +: 4]) || !is_bcd_digit(b[4*i +: 4]))
                ops_valid = 1'b0;
        end
    end

    // Negate pass subtracts the stored raw result from zero.
    always_comb begin
        sub_x = (state_q == S_NEG) ? 4'd0 : a_q[3:0];
        sub_y = (state_q == S_NEG) ? r_q[3:0] : b_q[3:0];
    end

    bcd_digit_sub u_digit_sub (
        .x    (sub_x),
        .y    (sub_y),
        .bin  (borrow_q),
        .d    (sub_d),
        .bout (sub_bout)
    );

    // Next-state, datapath sequencing and result capture.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        neg_d    = neg_q;
        inv_d    = inv_q;
        r_shift  = (r_q >> 4) | (W'(sub_d) << (W - 4));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    r_d      = '0;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    diff_d   = '0;
                    neg_d    = 1'b0;
                    inv_d    = !ops_valid;
                    state_d  = ops_valid ? S_SUB : S_FIN;
                end
            end
            S_SUB: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                r_d      = r_shift;
                borrow_d = sub_bout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (sub_bout) begin
                        // Raw result is the ten's complement; negate it next.
                        borrow_d = 1'b0;
                        state_d  = S_NEG;
                    end else begin
                        diff_d  = r_shift;
                        neg_d   = 1'b0;
                        state_d = S_FIN;
                    end
                end
            end
            S_NEG: begin
                r_d      = r_shift;
                borrow_d = sub_bout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // The final borrow is always set here and carries no information.
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    diff_d   = r_shift;
                    neg_d    = 1'b1;
                    state_d  = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            neg_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            neg_q    <= neg_d;
            inv_q    <= inv_d;
        end
    end

    assign busy    = (state_q == S_SUB) || (state_q == S_NEG);
    assign done    = (state_q == S_FIN);
    assign diff    = diff_q;
    assign neg     = neg_q;
    assign invalid = inv_q;

endmodule
